// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: buffers fetched {inst, pc} pairs for decode.
// Backpressures fetch when full and drops everything on a branch flush.
module if_id_buffer #(
    parameter int          DEPTH = 2,
    parameter int          PTR_W = 1,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    if_id_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        out_inst = NOP;
        out_pc   = '0;
        if (out_valid) begin
            out_inst = mem[rd_ptr].inst;
            out_pc   = mem[rd_ptr].pc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (push & ~pop): count <= count + 1'b1;
                (pop & ~push): count <= count - 1'b1;
                default:       count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a queue model tracks accepted entries
// and every cycle the DUT outputs are compared against its head.
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam int          PTR_W = 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic [31:0]    in_inst = '0;
    logic [31:0]    in_pc = '0;
    logic           in_ready;
    logic           out_valid;
    logic [31:0]    out_inst;
    logic [31:0]    out_pc;
    logic           out_ready = 1'b0;
    logic [PTR_W:0] count;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    if_id_buffer #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W),
        .NOP  (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {pc[11:0], 20'h00093};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_inst", 64'(out_inst), 64'(sb[0].inst));
            chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
        end else begin
            chk("out_inst_nop", 64'(out_inst), 64'(NOP));
            chk("out_pc_zero", 64'(out_pc), 64'h0);
        end
    endtask

    // Called at negedge: check outputs, drive inputs, model the next edge.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        logic full;
        logic empty;
        check_out();
        in_valid  = v;
        in_inst   = mk(pc);
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        full  = (sb.size() == DEPTH);
        empty = (sb.size() == 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (!empty && rdy) void'(sb.pop_front());
            if (v && !full) sb.push_back('{inst: mk(pc), pc: pc});
        end
        @(negedge clk);
    endtask

    task automatic step_raw(input logic [31:0] inst, input logic [31:0] pc,
                            input logic rdy);
        check_out();
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = 1'b0;
        @(posedge clk);
        if (sb.size() != 0 && rdy) void'(sb.pop_front());
        if (sb.size() < DEPTH) sb.push_back('{inst: inst, pc: pc});
        @(negedge clk);
    endtask

    initial begin
        // reset and empty
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_out();
        end
        rst = 1'b1;
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);

        // single pass-through
        step_raw(32'h00500093, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // fill and backpressure
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b1, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // streaming and pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(4 * i), 1'b1, 1'b0);
        end
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

        // flush over a full buffer with a same-cycle offer
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b1, 1'b1);
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // async reset between edges
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h4, 1'b0, 1'b0);
        check_out();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        check_out();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b1, 32'h84, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling queue between the instruction fetch stage and the decode stage of the MiniRiscV pipeline.
- Captures each fetched instruction with its PC and presents it in order to decode through a valid/ready handshake.
- Backpressures fetch when full; its in_ready drives fetch's stall input as stall = !in_ready.
- Discards all buffered instructions on a taken-branch flush.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, 1, pointer width; must equal log2(DEPTH).
- NOP, 32'h00000013, instruction word driven on out_inst when the buffer is empty (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  taken-branch flush; empties the buffer.
- in_valid  input  1  fetch presents a valid instruction.
- in_inst  input  32  fetched instruction word.
- in_pc  input  32  byte address of in_inst.
- in_ready  output  1  buffer can accept; fetch stall = !in_ready.
- out_valid  output  1  head entry valid.
- out_inst  output  32  head instruction, or NOP when empty.
- out_pc  output  32  head PC, or 0 when empty.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
Reset:
- rst low asynchronously clears wr_ptr, rd_ptr and count to 0.
- Outputs while in reset: out_valid=0, out_inst=NOP, out_pc=0, in_ready=1.
- Storage contents need not be cleared.
- Reset asserted mid-operation drops all entries immediately, with no wait for a clock edge.

Handshake:
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- in_ready = (count != DEPTH). It depends only on registered state, never combinationally on out_ready or in_valid.
- out_valid = (count != 0).
- out_inst and out_pc are driven combinationally from storage[rd_ptr] when out_valid=1, otherwise NOP and 0.
- No data path bypasses storage.

Latency:
- An instruction pushed at edge N is visible on the outputs after edge N, i.e. 1 cycle, even when the buffer is empty.

Update at posedge clk:
- flush=1: wr_ptr<=0, rd_ptr<=0, count<=0. Any same-cycle in_valid is discarded and any same-cycle out_ready is ignored. Flush has priority over push and pop.
- push only: storage[wr_ptr]<={in_inst,in_pc}, wr_ptr<=wr_ptr+1, count<=count+1.
- pop only: rd_ptr<=rd_ptr+1, count<=count-1.
- push and pop together (possible when 0<count<DEPTH): write and advance both pointers; count unchanged.
- Neither push nor pop: hold all state.

Wrap-around and bounds:
- Pointers wrap modulo DEPTH through natural PTR_W overflow.
- Full: in_ready=0. in_valid is ignored and fetch must hold its instruction; the stall covers this.
- Empty: out_valid=0 and out_ready is ignored; count never underflows.
- Storage must be written only on push.

Ordering: FIFO; entries leave in push order.

Test Plan:
1. Reset and empty: hold rst=0 for 3 cycles, then release. Required: count=0, out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1. With out_ready=1 and in_valid=0 for 5 cycles, count stays 0.
2. Single pass-through: push {inst=32'h00500093, pc=0}, out_ready=1. Required: next cycle out_valid=1, out_inst=32'h00500093, out_pc=0. The cycle after, out_valid=0 and count=0.
3. Fill and backpressure: out_ready=0, push pc=0,4,8. Required: count=2 and in_ready=0 after the second push; the pc=8 offer is not accepted. Set out_ready=1 for one cycle: head pc=0 pops, in_ready=1, and pc=8 is accepted the following edge. Output order is 0,4,8.
4. Streaming and wrap: in_valid=1 and out_ready=1 continuously for 10 instructions, pc=0..36 step 4. Required: one instruction per cycle on output in order, count stays 1 after the first push, pointers wrap at least 4 times, no loss or duplication.
5. Flush with full buffer and simultaneous input: count=2 holding pc 0 and 4, then flush=1 with in_valid=1 and pc=8 in the same cycle. Required: next cycle count=0, out_valid=0, out_inst=NOP, and pc=8 is absent. A following push of pc=0x40 appears as the head.
6. Async reset mid-stream: with count=2, pulse rst low between clock edges. Required: out_valid=0, count=0 and in_ready=1 immediately, before the next edge. After release, normal push/pop resumes.
